uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, range 2..256.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  push request from the producer.
REQ-005 SHALL have port wr_data  input  8  byte to push.
REQ-006 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-007 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-008 SHALL have port level  output  $clog2(DEPTH)+1  stored byte count; excludes the byte in flight.
REQ-009 SHALL have port tx_start  output  1  one-cycle launch pulse to the uarttx stage.
REQ-010 SHALL have port tx_byte  output  8  byte to the uarttx stage; registered.
REQ-011 SHALL have port tx_ready  input  1  idle indication from the uarttx stage.

Function
REQ-012 SHALL store bytes in a circular buffer with rd/wr pointers one bit wider than log2(DEPTH); wrap-around is by natural overflow.
REQ-013 SHALL derive full, empty and level combinationally from the pointers: full = MSBs differ and low bits equal; empty = pointers equal.
REQ-014 SHALL accept a push iff wr_en && !full in that cycle; a push while full is dropped and leaves all state unchanged, even if a pop occurs in the same cycle.
REQ-015 SHALL run a drain FSM with states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with !empty && tx_ready, SHALL load tx_byte from the head entry, pop (rd_ptr+1), set tx_start, and go to LAUNCH.
REQ-017 In LAUNCH, SHALL hold tx_start high for exactly this one cycle, then clear it and go to WAIT_BUSY.
REQ-018 In WAIT_BUSY, SHALL go to WAIT_DONE when tx_ready==0; no timeout.
REQ-019 In WAIT_DONE, SHALL go to IDLE when tx_ready==1.
REQ-020 SHALL hold tx_byte stable from the LAUNCH cycle until the next launch, because uarttx samples the data bits throughout the frame.
REQ-021 A simultaneous accepted push and pop SHALL both take effect, with level unchanged.
REQ-022 Write-to-tx_start latency from an empty FIFO with tx_ready=1 SHALL be 2 cycles: push at N, IDLE decision at N+1, tx_start high at N+2.
REQ-023 SHALL start no launch in the same cycle as a push into an empty FIFO.
REQ-024 SHALL never assert tx_start outside LAUNCH.
REQ-025 SHALL allow back-to-back frames no closer than one IDLE cycle after tx_ready returns high.

Reset
REQ-026 On rst, SHALL clear both pointers and set state IDLE, tx_start=0, tx_byte=0, full=0, empty=1, level=0.
REQ-027 SHALL flush all stored bytes on reset and not abort a uarttx frame in progress; after reset, IDLE waits for tx_ready==1 before any launch.

Configuration
REQ-028 With UART_TX_FIFO_OVERFLOW_EN defined, SHALL add input clr_overflow (1) and output overflow (1); overflow is set by a dropped push (wr_en && full), cleared by clr_overflow, and set wins over clear in the same cycle; overflow reset value is 0.
REQ-029 With UART_TX_FIFO_OVERFLOW_EN undefined, SHALL omit both ports and drop overflowing pushes silently.

Structure
REQ-030 SHALL place the FSM state enum and UART_BYTE_W=8 in shared package uart_pkg.
REQ-031 SHALL implement storage in sub-module uart_fifo_ram: DEPTH x 8, one synchronous write port, one asynchronous read port, no reset on contents.
REQ-032 SHALL keep pointers, flags and the FSM in uart_tx_fifo.

Verification
REQ-033 Single byte: push 0xA5 at cycle 0 with tx_ready=1 -> tx_start high only at cycle 2, tx_byte=0xA5, empty=1 from cycle 2.
REQ-034 Fill: push 16 bytes 0x00..0x0F with tx_ready=0 -> full=1, level=16; 17th push 0xFF dropped; uarttx output then shows 0x00..0x0F in order with no 0xFF.
REQ-035 Hold: while a frame is in progress (tx_ready=0), push new bytes -> tx_byte holds its value, and the next tx_start comes only after tx_ready rises then one IDLE cycle.
REQ-036 Wrap: push/pop 40 bytes with mixed traffic at DEPTH=4 -> the order is preserved and level never exceeds 4.
REQ-037 Reset mid-frame: rst at level=5 during WAIT_BUSY -> level=0, tx_start=0, and no launch before tx_ready==1.
REQ-038 Overflow (macro defined): 17 pushes at DEPTH=16 -> overflow=1; clr_overflow pulse -> overflow=0; clear and drop in the same cycle -> overflow=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uarttx feeder: byte width and drain FSM states.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x byte storage: one synchronous write port and one asynchronous read port.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [UART_BYTE_W-1:0] wr_data_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic [UART_BYTE_W-1:0] rd_data_o
);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];

  // NOTE: contents are deliberately not reset; the pointers alone decide which
  // entries are valid, and a resettable array would cost a flop per bit.
  // Sequential state is always assigned with <= so every reader sees the
  // pre-edge value regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uarttx stage: circular buffer plus a four-state drain FSM.
// Defining UART_TX_FIFO_OVERFLOW_EN adds a sticky overflow flag with clear input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tx_start,
  output logic [UART_BYTE_W-1:0] tx_byte,
  input  logic                   tx_ready
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  input  logic                   clr_overflow,
  output logic                   overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   push;
  logic                   pop;
  logic [UART_BYTE_W-1:0] head_byte;

  tx_state_e              state_q;
  logic                   tx_start_q;
  logic [UART_BYTE_W-1:0] tx_byte_q;

  // Extra pointer MSB separates "full" from "empty" when the low bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;

  assign push = wr_en && !full;
  assign pop  = (state_q == ST_IDLE) && !empty && tx_ready;

  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (head_byte)
  );

  // tx_byte only changes on a launch, so it stays valid for the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            tx_byte_q  <= head_byte;
            tx_start_q <= 1'b1;
            state_q    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tx_start_q <= 1'b0;
          state_q    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!tx_ready) begin
            state_q <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (wr_en && full) begin
      overflow_q <= 1'b1;
    end else if (clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
`else
  // Pushes into a full FIFO are discarded with no indication.
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue model of stored bytes, monitor on tx_start,
// directed timing checks plus randomized traffic at DEPTH=16 and DEPTH=4.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int DEPTH4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic                   wr_en = 1'b0;
  logic [7:0]             wr_data = 8'h00;
  logic                   full, empty, tx_start;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             tx_byte;
  logic                   tx_ready;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic                   clr_overflow = 1'b0;
  logic                   overflow;
`endif

  // DEPTH=4 instance
  logic                    wr_en4 = 1'b0;
  logic [7:0]              wr_data4 = 8'h00;
  logic                    full4, empty4, tx_start4;
  logic [$clog2(DEPTH4):0] level4;
  logic [7:0]              tx_byte4;
  logic                    tx_ready4;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic                    clr4 = 1'b0;
  logic                    ovf4;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_start (tx_start),
    .tx_byte  (tx_byte),
    .tx_ready (tx_ready)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .clr_overflow (clr_overflow),
    .overflow     (overflow)
`endif
  );

  uart_tx_fifo #(.DEPTH(DEPTH4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en4),
    .wr_data  (wr_data4),
    .full     (full4),
    .empty    (empty4),
    .level    (level4),
    .tx_start (tx_start4),
    .tx_byte  (tx_byte4),
    .tx_ready (tx_ready4)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .clr_overflow (clr4),
    .overflow     (ovf4)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: bytes held in the FIFO, oldest first.
  logic [7:0] model_q[$];
  logic [7:0] model4_q[$];
  bit         ovf_exp = 1'b0;
  int         acc4 = 0;
  int         got4 = 0;

  // uarttx stand-ins. Manual mode follows ready_force; auto mode goes busy after
  // each launch. Updates land 2 time units after the falling edge so that any
  // change the stimulus makes at that edge applies to the same cycle.
  bit auto_uart   = 1'b0;
  bit ready_force = 1'b1;
  int ust  = 0;
  int ucnt = 0;

  always @(negedge clk) begin
    #2;
    if (!auto_uart) begin
      tx_ready = ready_force;
      ust  = 1;
      ucnt = 1;
    end else begin
      case (ust)
        0: begin
          tx_ready = 1'b1;
          if (tx_start) begin
            ust  = 1;
            ucnt = $urandom_range(0, 1);
          end
        end
        1: begin
          if (ucnt == 0) begin
            tx_ready = 1'b0;
            ust  = 2;
            ucnt = $urandom_range(1, 4);
          end else begin
            ucnt--;
          end
        end
        default: begin
          ucnt--;
          if (ucnt == 0) begin
            tx_ready = 1'b1;
            ust = 0;
          end
        end
      endcase
    end
  end

  int ust4  = 0;
  int ucnt4 = 0;

  always @(negedge clk) begin
    #2;
    case (ust4)
      0: begin
        tx_ready4 = 1'b1;
        if (tx_start4) begin
          ust4  = 1;
          ucnt4 = $urandom_range(0, 1);
        end
      end
      1: begin
        if (ucnt4 == 0) begin
          tx_ready4 = 1'b0;
          ust4  = 2;
          ucnt4 = $urandom_range(1, 6);
        end else begin
          ucnt4--;
        end
      end
      default: begin
        ucnt4--;
        if (ucnt4 == 0) begin
          tx_ready4 = 1'b1;
          ust4 = 0;
        end
      end
    endcase
  end

  // Monitors: pop the scoreboard on every launch, check tx_byte holds otherwise.
  int         n_starts  = 0;
  int         start_cyc = -1;
  logic [7:0] hold_byte = 8'h00;
  bit         prev_start = 1'b0;

  always @(posedge clk) begin
    logic [7:0] exp_b;
    #1;
    if (rst) begin
      hold_byte  = 8'h00;
      prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        n_starts++;
        start_cyc = cyc;
        check("launch_not_back_to_back", prev_start, 0);
        check("ready_before_launch", tx_ready, 1);
        check("scoreboard_has_entry", model_q.size() != 0, 1);
        if (model_q.size() != 0) begin
          exp_b = model_q.pop_front();
          check("tx_byte_order", tx_byte, exp_b);
          hold_byte = exp_b;
        end
      end else begin
        check("tx_byte_hold", tx_byte, hold_byte);
      end
      prev_start = tx_start;
    end
  end

  always @(posedge clk) begin
    logic [7:0] exp_b;
    #1;
    if (!rst && tx_start4) begin
      check("d4_scoreboard_has_entry", model4_q.size() != 0, 1);
      if (model4_q.size() != 0) begin
        exp_b = model4_q.pop_front();
        check("d4_tx_byte_order", tx_byte4, exp_b);
        got4++;
      end
    end
  end

  // One clock of stimulus for the DEPTH=16 instance, with per-cycle flag checks.
  task automatic step(input bit we, input logic [7:0] d, input bit clr = 1'b0);
    @(negedge clk);
    if (!rst) begin
      check("level", level, model_q.size());
      check("full", full, model_q.size() == DEPTH);
      check("empty", empty, model_q.size() == 0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      check("overflow", overflow, ovf_exp);
`endif
    end
    wr_en   = we;
    wr_data = d;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    clr_overflow = clr;
`endif
    if (we && model_q.size() >= DEPTH) ovf_exp = 1'b1;
    else if (clr)                      ovf_exp = 1'b0;
    if (we && model_q.size() < DEPTH) model_q.push_back(d);
  endtask

  task automatic step4(input bit we, input logic [7:0] d);
    @(negedge clk);
    check("d4_level", level4, model4_q.size());
    check("d4_level_max", level4 <= DEPTH4, 1);
    check("d4_full", full4, model4_q.size() == DEPTH4);
    check("d4_empty", empty4, model4_q.size() == 0);
    wr_en4   = we;
    wr_data4 = d;
    if (we && model4_q.size() < DEPTH4) begin
      model4_q.push_back(d);
      acc4++;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (model_q.size() != 0 && t < 3000) begin
      step(1'b0, 8'h00);
      t++;
    end
    check(name, model_q.size(), 0);
    repeat (12) step(1'b0, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int p;
    int k;
    int n0;
    int t;
    int seg_p[3] = '{20, 55, 90};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_d4_empty", empty4, 1);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check("rst_overflow", overflow, 0);
`endif
    rst = 1'b0;
    repeat (3) step(1'b0, 8'h00);

    // Single byte: push at p, launch exactly at p+2
    step(1'b1, 8'hA5);
    p = cyc;
    step(1'b0, 8'h00);
    check("single_no_early_start", tx_start, 0);
    step(1'b0, 8'h00);
    check("single_start", tx_start, 1);
    check("single_start_cycle", start_cyc, p + 2);
    check("single_tx_byte", tx_byte, 8'hA5);
    check("single_empty", empty, 1);
    auto_uart = 1'b1;
    drain("single_drain");

    // Fill with the uarttx busy, then one dropped push
    auto_uart   = 1'b0;
    ready_force = 1'b0;
    step(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i));
    step(1'b1, 8'hFF);
    check("fill_full", full, 1);
    check("fill_level", level, 16);
    step(1'b0, 8'h00);
    check("fill_level_after_drop", level, 16);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check("ovf_set", overflow, 1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00);
    check("ovf_cleared", overflow, 0);
    step(1'b1, 8'hEE, 1'b1);
    step(1'b0, 8'h00);
    check("ovf_set_wins", overflow, 1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00);
`endif
    auto_uart = 1'b1;
    drain("fill_drain");

    // Hold: tx_byte stays put during a frame; next launch one IDLE cycle after ready
    auto_uart   = 1'b0;
    ready_force = 1'b1;
    repeat (2) step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("hold_first_start", tx_start, 1);
    ready_force = 1'b0;
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    repeat (4) step(1'b0, 8'h00);
    check("hold_tx_byte", tx_byte, 8'h3C);
    check("hold_no_start", tx_start, 0);
    ready_force = 1'b1;
    k = cyc;
    step(1'b0, 8'h00);
    check("hold_idle_gap", tx_start, 0);
    step(1'b0, 8'h00);
    check("hold_next_start", tx_start, 1);
    check("hold_next_cycle", start_cyc, k + 2);
    check("hold_next_byte", tx_byte, 8'h11);
    auto_uart = 1'b1;
    drain("hold_drain");

    // Reset mid-frame: level 5 while waiting for the uarttx to go busy
    auto_uart   = 1'b0;
    ready_force = 1'b1;
    repeat (2) step(1'b0, 8'h00);
    step(1'b1, 8'h77);
    repeat (2) step(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h81 + i));
    step(1'b0, 8'h00);
    check("midframe_level", level, 5);
    rst = 1'b1;
    model_q.delete();
    ovf_exp     = 1'b0;
    wr_en       = 1'b0;
    ready_force = 1'b0;
    #1;
    check("midframe_rst_level", level, 0);
    check("midframe_rst_tx_start", tx_start, 0);
    check("midframe_rst_empty", empty, 1);
    check("midframe_rst_tx_byte", tx_byte, 0);
    repeat (2) step(1'b0, 8'h00);
    rst = 1'b0;
    step(1'b1, 8'h90);
    step(1'b1, 8'h91);
    n0 = n_starts;
    repeat (5) step(1'b0, 8'h00);
    check("midframe_no_launch_while_busy", n_starts, n0);
    ready_force = 1'b1;
    k = cyc;
    step(1'b0, 8'h00);
    check("midframe_launch_after_ready", tx_start, 1);
    check("midframe_launch_cycle", start_cyc, k + 1);
    auto_uart = 1'b1;
    drain("midframe_drain");

    // Randomized traffic at three push rates
    for (int s = 0; s < 3; s++) begin
      repeat (300) step($urandom_range(0, 99) < seg_p[s], 8'($urandom),
                        $urandom_range(0, 15) == 0);
    end
    drain("random_drain");

    // DEPTH=4: 40 accepted bytes under mixed traffic, order and bound checked
    t = 0;
    while (acc4 < 40 && t < 3000) begin
      step4($urandom_range(0, 99) < 60, 8'($urandom));
      t++;
    end
    check("d4_accepted", acc4, 40);
    t = 0;
    while (model4_q.size() != 0 && t < 3000) begin
      step4(1'b0, 8'h00);
      t++;
    end
    check("d4_drained", got4, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
